// File: rtl/stimulus_gen_if.sv
// -----------------------------------------------------------------------------
// stimulus_gen_if
//   Operand bus between the stimulus generator (producer) and its consumers
//   (the DUT and the result monitor).
//
//   dut_ia  WIDTH  operand A
//   dut_ib  WIDTH  operand B
//   valid   1      operands are a live test vector this cycle
//
//   master : producer side (drives all signals)
//   slave  : consumer side (samples all signals)
// -----------------------------------------------------------------------------
interface stimulus_gen_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] dut_ia;
  logic [WIDTH-1:0] dut_ib;
  logic             valid;

  modport master (output dut_ia, output dut_ib, output valid);
  modport slave  (input  dut_ia, input  dut_ib, input  valid);
endinterface

// File: rtl/stimulus_gen.sv
// -----------------------------------------------------------------------------
// stimulus_gen
//   Operand-pair producer for a float32 DUT and its monitor. A run sweeps 16
//   float32 corner pairs, then issues i_num_vec pseudo-random pairs from two
//   Galois LFSRs (or runs until i_stop when i_num_vec is 0), then idles for
//   DRAIN_CYCLES so in-flight monitor checks still land, then reports DONE.
//   Monitor mismatch pulses are counted per run with saturation.
//
// Ports
//   clk          in   1      clock, all logic on posedge
//   reset        in   1      synchronous, active-high
//   i_start      in   1      start a run (accepted only in IDLE or DONE)
//   i_stop       in   1      end stimulus early (CORNER/RANDOM only)
//   i_num_vec    in   CNT_W  random vectors per run, 0 = until i_stop
//   i_seed       in   WIDTH  LFSR seed
//   i_event      in   1      mismatch pulse from the monitor
//   o_bus        master      operand bus: dut_ia, dut_ib, valid (registered)
//   o_busy       out  1      state is CORNER, RANDOM or DRAIN
//   o_done       out  1      state is DONE
//   o_vec_count  out  CNT_W  vectors issued this run, wraps
//   o_err_count  out  ERR_W  events counted this run, saturates
// -----------------------------------------------------------------------------
module stimulus_gen #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 32,
  parameter int ERR_W        = 16,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [CNT_W-1:0]  i_num_vec,
  input  logic [WIDTH-1:0]  i_seed,
  input  logic              i_event,
  stimulus_gen_if.master    o_bus,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_vec_count,
  output logic [ERR_W-1:0]  o_err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORNER,
    S_RANDOM,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int              DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [WIDTH-1:0] LFSR_MASK  = WIDTH'(32'h8020_0003);
  localparam logic [WIDTH-1:0] SEED_GUARD = WIDTH'(32'h0000_0001);

  // Corner table: +0, 1.0, +inf, minimum denormal.
  function automatic logic [WIDTH-1:0] corner_val(input logic [1:0] sel);
    case (sel)
      2'd0:    return WIDTH'(32'h0000_0000);
      2'd1:    return WIDTH'(32'h3F80_0000);
      2'd2:    return WIDTH'(32'h7F80_0000);
      default: return WIDTH'(32'h0000_0001);
    endcase
  endfunction

  // Galois LFSR, right shift, feedback mask applied when the LSB shifts out.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_MASK : '0);
  endfunction

  state_t             r_state;
  logic               r_start_pend;
  logic [3:0]         r_idx;
  logic [CNT_W-1:0]   r_num_vec;
  logic [CNT_W-1:0]   r_rand_cnt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [WIDTH-1:0]   r_lfsr_a;
  logic [WIDTH-1:0]   r_lfsr_b;
  logic [WIDTH-1:0]   r_dut_ia;
  logic [WIDTH-1:0]   r_dut_ib;
  logic               r_valid;
  logic [CNT_W-1:0]   r_vec_count;
  logic [ERR_W-1:0]   r_err_count;

  logic [3:0]         w_idx_next;
  logic               w_count_evt;
  logic               w_rand_last;
  logic [WIDTH-1:0]   w_seed_b;

  assign w_idx_next  = r_idx + 4'd1;
  assign w_count_evt = i_event && (r_state == S_CORNER || r_state == S_RANDOM ||
                                   r_state == S_DRAIN);
  assign w_rand_last = (r_num_vec != '0) && (r_rand_cnt == r_num_vec);
  assign w_seed_b    = ~i_seed;

  // Accepting i_start takes one edge (latch seeds/count, clear counters); the
  // following edge puts corner pair 0 on the bus. This keeps the bus aligned
  // with the state: o_valid is 1 exactly in CORNER/RANDOM cycles.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values of each other; blocking = would make the result depend on
  // statement order. Reset is synchronous, so it is just the first branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start_pend <= 1'b0;
      r_idx        <= '0;
      r_num_vec    <= '0;
      r_rand_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_lfsr_a     <= '0;
      r_lfsr_b     <= '0;
      r_dut_ia     <= '0;
      r_dut_ib     <= '0;
      r_valid      <= 1'b0;
      r_vec_count  <= '0;
      r_err_count  <= '0;
    end else begin
      if (w_count_evt && r_err_count != '1) begin
        r_err_count <= r_err_count + 1'b1;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (r_start_pend) begin
            r_start_pend <= 1'b0;
            r_state      <= S_CORNER;
            r_idx        <= '0;
            r_dut_ia     <= corner_val(2'd0);
            r_dut_ib     <= corner_val(2'd0);
            r_valid      <= 1'b1;
            r_vec_count  <= r_vec_count + 1'b1;
          end else if (i_start) begin
            r_start_pend <= 1'b1;
            r_num_vec    <= i_num_vec;
            r_lfsr_a     <= (i_seed   == '0) ? SEED_GUARD : i_seed;
            r_lfsr_b     <= (w_seed_b == '0) ? SEED_GUARD : w_seed_b;
            r_vec_count  <= '0;
            r_err_count  <= '0;
          end
        end

        S_CORNER: begin
          if (i_stop) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            r_dut_ia    <= '0;
            r_dut_ib    <= '0;
            r_valid     <= 1'b0;
          end else if (r_idx == 4'd15) begin
            // First random vector is the loaded seed pair itself.
            r_state     <= S_RANDOM;
            r_rand_cnt  <= CNT_W'(1);
            r_dut_ia    <= r_lfsr_a;
            r_dut_ib    <= r_lfsr_b;
            r_lfsr_a    <= lfsr_step(r_lfsr_a);
            r_lfsr_b    <= lfsr_step(r_lfsr_b);
            r_vec_count <= r_vec_count + 1'b1;
          end else begin
            r_idx       <= w_idx_next;
            r_dut_ia    <= corner_val(w_idx_next[3:2]);
            r_dut_ib    <= corner_val(w_idx_next[1:0]);
            r_vec_count <= r_vec_count + 1'b1;
          end
        end

        S_RANDOM: begin
          if (i_stop || w_rand_last) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            r_dut_ia    <= '0;
            r_dut_ib    <= '0;
            r_valid     <= 1'b0;
          end else begin
            r_rand_cnt  <= r_rand_cnt + 1'b1;
            r_dut_ia    <= r_lfsr_a;
            r_dut_ib    <= r_lfsr_b;
            r_lfsr_a    <= lfsr_step(r_lfsr_a);
            r_lfsr_b    <= lfsr_step(r_lfsr_b);
            r_vec_count <= r_vec_count + 1'b1;
          end
        end

        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_bus.dut_ia = r_dut_ia;
  assign o_bus.dut_ib = r_dut_ib;
  assign o_bus.valid  = r_valid;
  assign o_busy       = (r_state == S_CORNER) || (r_state == S_RANDOM) || (r_state == S_DRAIN);
  assign o_done       = (r_state == S_DONE);
  assign o_vec_count  = r_vec_count;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_stimulus_gen.sv
// -----------------------------------------------------------------------------
// tb_stimulus_gen
//   Directed bench for stimulus_gen. A main instance (ERR_W=16) covers the
//   corner sweep, LFSR sequence, seed guard, stop/drain, event counting,
//   reset and restart; a second instance (ERR_W=4) covers error saturation.
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stimulus_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, stop, evt;
  logic [31:0] num_vec, seed;
  logic        busy, done;
  logic [31:0] vec_count;
  logic [15:0] err_count;

  logic        s_start, s_stop, s_evt;
  logic [31:0] s_num_vec, s_seed;
  logic        s_busy, s_done;
  logic [31:0] s_vec_count;
  logic [3:0]  s_err_count;

  stimulus_gen_if #(.WIDTH(32)) bus0 ();
  stimulus_gen_if #(.WIDTH(32)) bus1 ();

  stimulus_gen u_dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (start),
    .i_stop      (stop),
    .i_num_vec   (num_vec),
    .i_seed      (seed),
    .i_event     (evt),
    .o_bus       (bus0),
    .o_busy      (busy),
    .o_done      (done),
    .o_vec_count (vec_count),
    .o_err_count (err_count)
  );

  stimulus_gen #(.ERR_W(4)) u_dut_sat (
    .clk         (clk),
    .reset       (reset),
    .i_start     (s_start),
    .i_stop      (s_stop),
    .i_num_vec   (s_num_vec),
    .i_seed      (s_seed),
    .i_event     (s_evt),
    .o_bus       (bus1),
    .o_busy      (s_busy),
    .o_done      (s_done),
    .o_vec_count (s_vec_count),
    .o_err_count (s_err_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] t_tab [4] = '{32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0001};
  // Hand-stepped LFSR sequences for seed 0x1234_5678.
  logic [31:0] ra_tab [4] = '{32'h1234_5678, 32'h091A_2B3C, 32'h048D_159E, 32'h0246_8ACF};
  logic [31:0] rb_tab [4] = '{32'hEDCB_A987, 32'hF6C5_D4C0, 32'h7B62_EA60, 32'h3DB1_7530};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Leaves the bench at the falling edge of the accept cycle: the first
  // corner pair appears one cycle later, the first random pair 17 later.
  task automatic start_run(input logic [31:0] s, input logic [31:0] n);
    seed    = s;
    num_vec = n;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] a;

    reset = 1'b1; start = 1'b0; stop = 1'b0; evt = 1'b0; seed = '0; num_vec = '0;
    s_start = 1'b0; s_stop = 1'b0; s_evt = 1'b0; s_seed = '0; s_num_vec = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus0.valid), 32'd0);
    check("rst_ia",    bus0.dut_ia,      32'd0);
    check("rst_ib",    bus0.dut_ib,      32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_vec",   vec_count,        32'd0);
    check("rst_err",   32'(err_count),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full run, seed 0x1234_5678, 4 random vectors, with events at the first
    // corner cycle, second random vector, last drain cycle and in DONE.
    start_run(32'h1234_5678, 32'd4);
    check("accept_valid", 32'(bus0.valid), 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("corner%0d_a", i), bus0.dut_ia, t_tab[i / 4]);
      check($sformatf("corner%0d_b", i), bus0.dut_ib, t_tab[i % 4]);
      check($sformatf("corner%0d_valid", i), 32'(bus0.valid), 32'd1);
      check($sformatf("corner%0d_vec", i), vec_count, 32'(i + 1));
      evt = (i == 0);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("rand%0d_a", j), bus0.dut_ia, ra_tab[j]);
      check($sformatf("rand%0d_b", j), bus0.dut_ib, rb_tab[j]);
      check($sformatf("rand%0d_vec", j), vec_count, 32'(17 + j));
      evt = (j == 1);
    end
    for (int d = 0; d < 8; d++) begin
      @(negedge clk);
      check($sformatf("drain%0d_valid", d), 32'(bus0.valid), 32'd0);
      check($sformatf("drain%0d_busy", d), 32'(busy), 32'd1);
      evt = (d == 7);
    end
    @(negedge clk);
    check("run1_done", 32'(done),      32'd1);
    check("run1_busy", 32'(busy),      32'd0);
    check("run1_ia",   bus0.dut_ia,    32'd0);
    check("run1_vec",  vec_count,      32'd20);
    check("run1_err",  32'(err_count), 32'd3);
    evt = 1'b1;
    @(negedge clk);
    evt = 1'b0;
    check("done_evt_ignored", 32'(err_count), 32'd3);

    // Zero-seed guard on each LFSR.
    start_run(32'hFFFF_FFFF, 32'd1);
    check("restart_vec_clr", vec_count,      32'd0);
    check("restart_err_clr", 32'(err_count), 32'd0);
    repeat (17) @(negedge clk);
    check("seed_ff_a", bus0.dut_ia, 32'hFFFF_FFFF);
    check("seed_ff_b", bus0.dut_ib, 32'h0000_0001);
    wait_done("seed_ff_done");
    start_run(32'h0000_0000, 32'd1);
    repeat (17) @(negedge clk);
    check("seed_0_a", bus0.dut_ia, 32'h0000_0001);
    check("seed_0_b", bus0.dut_ib, 32'hFFFF_FFFF);
    wait_done("seed_0_done");

    // Unbounded run stopped on the 100th random vector; i_start in DRAIN.
    start_run(32'h0000_ACE1, 32'd0);
    a = 32'h0000_ACE1;
    repeat (17) @(negedge clk);
    for (int k = 1; k < 100; k++) begin
      a = lfsr_step(a);
      @(negedge clk);
    end
    check("stop_a",     bus0.dut_ia,      a);
    check("stop_valid", 32'(bus0.valid),  32'd1);
    check("stop_vec",   vec_count,        32'd116);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_drain_valid", 32'(bus0.valid), 32'd0);
    check("stop_drain_busy",  32'(busy),       32'd1);
    check("stop_drain_vec",   vec_count,       32'd116);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("stop_done");
    check("drain_start_ignored", vec_count, 32'd116);

    // Restart from DONE with the first seed reproduces the same sequence.
    start_run(32'h1234_5678, 32'd4);
    repeat (17) @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("rerun%0d_a", j), bus0.dut_ia, ra_tab[j]);
      check($sformatf("rerun%0d_b", j), bus0.dut_ib, rb_tab[j]);
      @(negedge clk);
    end
    wait_done("rerun_done");
    check("rerun_vec", vec_count,      32'd20);
    check("rerun_err", 32'(err_count), 32'd0);

    // Reset mid-RANDOM aborts the run.
    start_run(32'h1234_5678, 32'd0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(bus0.valid), 32'd0);
    check("midrst_ia",    bus0.dut_ia,     32'd0);
    check("midrst_ib",    bus0.dut_ib,     32'd0);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_done",  32'(done),       32'd0);
    check("midrst_vec",   vec_count,       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Saturation on the 4-bit error counter.
    s_seed    = 32'h0000_0001;
    s_num_vec = 32'd0;
    s_start   = 1'b1;
    @(negedge clk);
    s_start   = 1'b0;
    @(negedge clk);
    s_evt = 1'b1;
    repeat (14) @(negedge clk);
    check("sat_14", 32'(s_err_count), 32'h0000_000E);
    repeat (6) @(negedge clk);
    s_evt = 1'b0;
    check("sat_20", 32'(s_err_count), 32'h0000_000F);
    s_stop = 1'b1;
    @(negedge clk);
    s_stop = 1'b0;
    check("sat_hold", 32'(s_err_count), 32'h0000_000F);
    check("sat_busy", 32'(s_busy),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
